// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake bundle between the calculator control FSM
// (master) and the binary-to-BCD converter (slave).
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    // Requester side: launches conversions and consumes results.
    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  ovf
    );

    // Converter side.
    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// An accepted start captures the operand; BIN_W shift cycles later the
// packed BCD digits and the overflow flag are published with a one-cycle
// done pulse. Operands >= 10^DIGITS yield the operand mod 10^DIGITS with
// ovf set, because bits carried out of the top digit are simply dropped.
module bin2bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic         clock_i,
    input  logic         reset_i,   // asynchronous, active-low
    bin2bcd_seq_if.slave bus
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;         // operand shift register
    logic [BCD_W-1:0]   scratch_q, scratch_d; // digits under construction
    logic               sticky_q, sticky_d;   // any bit lost off the top digit
    logic [CNT_W-1:0]   cnt_q, cnt_d;         // shifts remaining
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   adj;                  // scratch after the add-3 step

    // Add-3 correction: each digit >= 5 gets +3, digits are independent.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4]
                          + ((scratch_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (which would infer a latch).
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        sticky_d  = sticky_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SHIFT;
                    bin_d     = bus.bin;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cnt_d     = CNT_W'(BIN_W);
                end
            end
            SHIFT: begin
                // {adj, bin_q} shifted left by one; the MSB of adj falls out.
                scratch_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d     = {bin_q[BIN_W-2:0], 1'b0};
                sticky_d  = sticky_q | adj[BCD_W-1];
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scratch_d;
                    ovf_d   = sticky_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock_i or negedge reset_i) begin
        // NOTE: the result registers are reset too, so a reset mid-conversion also clears the previously shown bcd.
        if (!reset_i) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            sticky_q  <= sticky_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: the driver pushes the reference result
// for each accepted start, an independent monitor pops and compares on done.
module tb_bin2bcd_seq;

    localparam int BIN_W  = 27;
    localparam int DIGITS = 8;
    localparam int BCD_W  = 4 * DIGITS;

    typedef struct {
        logic [BCD_W-1:0] bcd;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   start_cyc;
    int   done_cnt;
    int   tests;
    int   failed;
    exp_t sb[$];

    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by plain division, overflow by magnitude.
    function automatic exp_t model(input longint unsigned v);
        exp_t           e;
        longint unsigned lim = 1;
        longint unsigned r;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        r     = v % lim;
        e.ovf = (v >= lim);
        e.bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            e.bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return e;
    endfunction

    // Monitor: compares every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (bus.busy && bus.done) check("busy_done_overlap", 1, 0);
        if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bcd", 64'(bus.bcd), 64'(e.bcd));
                check("ovf", 64'(bus.ovf), 64'(e.ovf));
            end
        end
    end

    // Called at a negedge; start is seen at the following posedge.
    task automatic launch(input longint unsigned v);
        bus.bin   = BIN_W'(v);
        bus.start = 1'b1;
        sb.push_back(model(v));
        @(negedge clk);
        bus.start = 1'b0;
        bus.bin   = BIN_W'($urandom);
        start_cyc = cyc;
        check("busy_after_start", 64'(bus.busy), 1);
        check("done_low_after_start", 64'(bus.done), 0);
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < BIN_W + 10) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(bus.done), 1);
        check("latency", 64'(cyc - start_cyc), 64'(BIN_W));
    endtask

    task automatic convert(input longint unsigned v);
        launch(v);
        wait_done();
    endtask

    initial begin
        int dc;
        cyc = 0; tests = 0; failed = 0; done_cnt = 0; start_cyc = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_done", 64'(bus.done), 0);
        check("rst_bcd", 64'(bus.bcd), 0);
        check("rst_ovf", 64'(bus.ovf), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values, each launched on the done cycle of the previous one.
        convert(0);
        convert(12345678);
        convert(99999999);
        convert(100000000);
        convert(134217727);
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 0);
        check("bcd_holds", 64'(bus.bcd), 64'h34217727);

        // Random operands, mixing full range and the 10^8 boundary region.
        for (int i = 0; i < 20; i++) begin
            longint unsigned v;
            if (i % 4 == 3) v = 64'd99999990 + longint'($urandom_range(0, 20));
            else            v = longint'($urandom) & ((64'd1 << BIN_W) - 1);
            convert(v);
            if (i % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        @(negedge clk);

        // start and bin changes while busy are ignored.
        dc = done_cnt;
        launch(5);
        repeat (9) @(negedge clk);
        bus.bin   = BIN_W'(77);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_ignores_start", 64'(bus.busy), 1);
        wait_done();
        repeat (BIN_W + 8) @(negedge clk);
        check("single_done", 64'(done_cnt - dc), 1);
        check("bcd_after_ignore", 64'(bus.bcd), 64'h5);

        // Reset mid-conversion aborts without a done pulse.
        launch(42);
        repeat (12) @(negedge clk);
        dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 0);
        check("abort_bcd", 64'(bus.bcd), 0);
        check("abort_done", 64'(bus.done), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (BIN_W + 8) @(negedge clk);
        check("no_done_after_abort", 64'(done_cnt - dc), 0);
        convert(42);
        @(negedge clk);
        check("bcd_after_abort", 64'(bus.bcd), 64'h42);
        check("sb_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter for the calculator datapath. It takes an unsigned binary result, for example the calculator accumulator, and produces packed 8-digit BCD for the display buffers. It replaces wide combinational divide/modulo chains with a shift-and-add-3 (double-dabble) engine that runs one bit per clock. A start/busy/done handshake lets the calculator control FSM launch a conversion and wait for the result.

## Interface
Parameters:
- BIN_W, 27: binary input width. 27 bits covers 0..134,217,727.
- DIGITS, 8: number of BCD digits produced. The BCD output is 4*DIGITS bits.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion. Sampled only when idle.
- bin  in  BIN_W  unsigned binary operand. Captured on the accepted start edge.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd/ovf are updated.
- bcd  out  4*DIGITS  packed BCD result; digit 0 is bits [3:0]. Holds its value between conversions.
- ovf  out  1  high if the last converted operand was >= 10^DIGITS. Holds with bcd.

## Operation
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1.
- IDLE to SHIFT, on a clock edge where start=1:
  - Capture bin into a shift register.
  - Clear the scratch BCD digits and the sticky overflow bit.
  - Load the bit counter with BIN_W.
- SHIFT, each cycle, in this order:
  - Every scratch digit >= 5 gets +3 (all digits in parallel, 4-bit arithmetic, no carry between digits).
  - The concatenation {scratch digits, binary shift register} shifts left by one.
  - The bit leaving the top digit is ORed into the sticky overflow bit.
  - The counter decrements.
- On the shift edge where the counter reaches 0 (i.e. shift BIN_W):
  - bcd <= the post-shift scratch digits.
  - ovf <= the sticky bit, including the bit shifted out on this edge.
  - done <= 1, busy <= 0.
  - State returns to IDLE.
- Result on overflow: bcd equals the operand mod 10^DIGITS, and ovf=1. Dropping the carried-out bits is exact for the low digits; no saturation is applied.
- start while busy: ignored. No queuing and no restart.
- bin changes while busy: ignored; only the captured copy is used.
- start while done=1: state is already IDLE, so the request is accepted and done still deasserts on the next edge.
- Scratch digits are not visible externally. bcd changes only on the completion edge.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, busy=0, done=0, bcd=0, ovf=0, counter=0, scratch registers=0.
- Reset asserted mid-conversion: the conversion is aborted, no done pulse occurs, and the previous bcd is lost (reads 0).
- start sampled high at edge k:
  - busy=1 from just after edge k.
  - Shifts occur at edges k+1 through k+BIN_W.
  - At edge k+BIN_W: bcd/ovf update, done=1, busy=0.
  - At edge k+BIN_W+1: done=0.
- Latency: BIN_W clock cycles from the accepted start edge to done (27 with defaults).
- Throughput: with start held high, a new conversion is accepted at edge k+BIN_W+1, so one result every BIN_W+1 cycles.
- done is never high for more than one cycle. busy and done are never high together.

## Test plan
- Reset, then bin=0, start one cycle -> busy for 27 cycles, done pulse, bcd=32'h00000000, ovf=0.
- bin=12,345,678 -> bcd=32'h12345678, ovf=0; done exactly 27 cycles after the start edge.
- bin=99,999,999, then bin=100,000,000 -> first gives bcd=32'h99999999, ovf=0; second gives bcd=32'h00000000, ovf=1.
- bin=134,217,727 (all ones) -> bcd=32'h34217727, ovf=1.
- Conversion of 5 in progress; at cycle 10 change bin to 77 and pulse start -> request ignored; done once with bcd=32'h00000005; no second done.
- Start a conversion of 42, assert reset at cycle 13 -> busy=0, bcd=0, no done. After release, convert 42 -> bcd=32'h00000042.
